// File: rtl/spi_flash_reader.sv
// SPI-flash READ sequencer: CMD + 24-bit address out, LEN bytes in.
// Mode 0 (SCK idles low); one transaction per start/busy/done handshake.
module spi_flash_reader #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 4,
  parameter logic [7:0]  CMD     = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [7:0]  len,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        spi_ss,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(CS_GAP + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t        state, state_d;
  logic [DW-1:0] div_cnt, div_d;
  logic [11:0]   bit_cnt, bit_d;
  logic [11:0]   nbits;
  logic [GW-1:0] gap_cnt, gap_d;
  logic [30:0]   tx_sr, tx_d;
  logic [6:0]    rx_sr, rx_d;
  logic [7:0]    len_q, len_d;
  logic          busy_d, done_d, valid_d;
  logic          ss_d, sck_d, mosi_d;
  logic [7:0]    data_d;
  logic          sample;

  assign nbits  = 12'd32 + {1'b0, len_q, 3'b000};
  // MISO is taken on the first clk cycle of each SCK high phase, data bits only
  assign sample = (state == SHIFT) && spi_sck &&
                  (div_cnt == '0) && (bit_cnt >= 12'd32);

  always_comb begin
    state_d = state;
    div_d   = div_cnt;
    bit_d   = bit_cnt;
    gap_d   = gap_cnt;
    tx_d    = tx_sr;
    rx_d    = rx_sr;
    len_d   = len_q;
    busy_d  = busy;
    done_d  = 1'b0;
    valid_d = 1'b0;
    data_d  = rd_data;
    ss_d    = spi_ss;
    sck_d   = spi_sck;
    mosi_d  = spi_mosi;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          busy_d  = 1'b1;
          ss_d    = 1'b0;
          sck_d   = 1'b0;
          mosi_d  = CMD[7];
          tx_d    = {CMD[6:0], addr};
          len_d   = len;
          bit_d   = '0;
          div_d   = '0;
        end
      end
      SHIFT: begin
        if (div_cnt != DIV_LAST) begin
          div_d = div_cnt + 1'b1;
        end else begin
          div_d = '0;
          if (!spi_sck) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (bit_cnt == nbits - 12'd1) begin
              state_d = GAP;
              ss_d    = 1'b1;
              mosi_d  = 1'b0;
              gap_d   = '0;
            end else begin
              // zeros shift in behind the address, so DATA bits drive 0
              bit_d  = bit_cnt + 12'd1;
              mosi_d = tx_sr[30];
              tx_d   = {tx_sr[29:0], 1'b0};
            end
          end
        end
        if (sample) begin
          rx_d = {rx_sr[5:0], spi_miso};
          if (bit_cnt[2:0] == 3'd7) begin
            data_d  = {rx_sr, spi_miso};
            valid_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      len_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
      spi_ss   <= 1'b1;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      state    <= state_d;
      div_cnt  <= div_d;
      bit_cnt  <= bit_d;
      gap_cnt  <= gap_d;
      tx_sr    <= tx_d;
      rx_sr    <= rx_d;
      len_q    <= len_d;
      busy     <= busy_d;
      done     <= done_d;
      rd_valid <= valid_d;
      rd_data  <= data_d;
      spi_ss   <= ss_d;
      spi_sck  <= sck_d;
      spi_mosi <= mosi_d;
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: flash model on the pins, vector table,
// random transactions and hand-written abort/overlap/back-to-back runs.
module tb_spi_flash_reader;

  localparam int DIV = 2;
  localparam int GAP = 4;

  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [23:0] addr = 0;
  logic [7:0]  len = 0;
  logic        busy, done, rd_valid;
  logic [7:0]  rd_data;
  logic        spi_ss, spi_sck, spi_mosi;
  logic        spi_miso = 0;

  always #5 clk = ~clk;

  spi_flash_reader #(
    .CLK_DIV(DIV),
    .CS_GAP (GAP),
    .CMD    (8'h03)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .addr    (addr),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .spi_ss  (spi_ss),
    .spi_sck (spi_sck),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // flash model / pin monitor
  logic       mosi_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] fl_data[$];
  int rises = 0, ss_low = 0, hi_chg = 0;
  int done_n = 0, done_cyc = 0;
  int ss_fall_cyc = 0, ss_rise_cyc = 0, bit_i = 0;
  logic sck_p = 0, mosi_p = 0, ss_p = 1;
  logic [7:0] byte_v;

  always @(negedge clk) begin
    if (!spi_ss) ss_low++;
    if (!spi_ss && ss_p) begin
      ss_fall_cyc = cyc;
      bit_i = 0;
    end
    if (spi_ss && !ss_p) ss_rise_cyc = cyc;
    if (spi_sck && !sck_p) begin
      mosi_q.push_back(spi_mosi);
      rises++;
      bit_i++;
    end
    if (spi_sck && sck_p && spi_mosi != mosi_p) hi_chg++;
    if (!spi_sck && sck_p) begin
      if (bit_i >= 32 && (bit_i - 32) / 8 < fl_data.size()) begin
        byte_v = fl_data[(bit_i - 32) / 8];
        spi_miso = byte_v[7 - ((bit_i - 32) % 8)];
      end else begin
        spi_miso = 1'($urandom);
      end
    end
    if (rd_valid) rd_q.push_back(rd_data);
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    sck_p = spi_sck;
    mosi_p = spi_mosi;
    ss_p = spi_ss;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int model_lat(input int l);
    return 1 + (32 + 8 * l) * 2 * DIV + GAP;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_n < target && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", 64'(done_n >= target), 1);
  endtask

  task automatic load_flash(input int l);
    fl_data.delete();
    for (int i = 0; i < l; i++) fl_data.push_back(8'($urandom));
  endtask

  task automatic run_txn(input logic [23:0] a, input logic [7:0] l,
                         input int exp_lat, input int poke);
    int b0, r0, s0, d0, h0, t0, nb, ones;
    logic [31:0] w;
    nb = 32 + 8 * int'(l);
    load_flash(int'(l));
    b0 = mosi_q.size();
    r0 = rd_q.size();
    s0 = ss_low;
    d0 = done_n;
    h0 = hi_chg;
    start = 1;
    addr = a;
    len = l;
    t0 = cyc;
    tick();
    start = 0;
    addr = 24'($urandom);
    len = 8'($urandom_range(1, 9));
    if (poke > 0) begin
      repeat (poke) tick();
      start = 1;
      tick();
      start = 0;
    end
    wait_done(d0 + 1, exp_lat + 50);
    chk("done_lat", 64'(done_cyc - t0), 64'(exp_lat));
    chk("busy_at_done", 64'(busy), 0);
    chk("ss_low", 64'(ss_low - s0), 64'(nb * 2 * DIV));
    chk("sck_rises", 64'(mosi_q.size() - b0), 64'(nb));
    w = '0;
    for (int i = 0; i < 32; i++)
      if (b0 + i < mosi_q.size()) w = {w[30:0], mosi_q[b0 + i]};
    chk("mosi_hdr", 64'(w), 64'({8'h03, a}));
    ones = 0;
    for (int i = 32; i < nb; i++)
      if (b0 + i < mosi_q.size() && mosi_q[b0 + i]) ones++;
    chk("mosi_data0", 64'(ones), 0);
    chk("rd_count", 64'(rd_q.size() - r0), 64'(l));
    for (int i = 0; i < int'(l); i++)
      if (r0 + i < rd_q.size())
        chk("rd_byte", 64'(rd_q[r0 + i]), 64'(fl_data[i]));
    chk("mosi_stable", 64'(hi_chg - h0), 0);
    repeat (3) tick();
    chk("done_once", 64'(done_n - d0), 1);
  endtask

  typedef struct {
    logic [23:0] a;
    logic [7:0]  l;
    int          lat;
  } vec_t;

  vec_t vt[4];

  initial begin
    int d0, d1, r1, r0, t0, n;
    vt[0] = '{24'h123456, 8'd2, 197};
    vt[1] = '{24'hFFFFFF, 8'd0, 133};
    vt[2] = '{24'h000001, 8'd1, 165};
    vt[3] = '{24'hA5A5A5, 8'd3, 229};

    repeat (3) tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_valid", 64'(rd_valid), 0);
    chk("rst_data", 64'(rd_data), 0);
    chk("rst_ss", 64'(spi_ss), 1);
    chk("rst_sck", 64'(spi_sck), 0);
    chk("rst_mosi", 64'(spi_mosi), 0);
    rst = 0;
    repeat (2) tick();

    foreach (vt[i]) run_txn(vt[i].a, vt[i].l, vt[i].lat, 0);

    for (int i = 0; i < 5; i++) begin
      logic [7:0] l;
      l = 8'($urandom_range(0, 5));
      run_txn(24'($urandom), l, model_lat(int'(l)), 0);
    end

    // second start during the address phase must be ignored
    run_txn(24'h0F1E2D, 8'd2, model_lat(2), 60);

    // abort during the first data byte
    load_flash(2);
    r0 = rd_q.size();
    start = 1;
    addr = 24'h445566;
    len = 8'd2;
    tick();
    start = 0;
    n = 0;
    while (bit_i < 36 && n < 1000) begin
      tick();
      n++;
    end
    chk("abort_reached", 64'(bit_i >= 36), 1);
    rst = 1;
    tick();
    chk("abort_ss", 64'(spi_ss), 1);
    chk("abort_sck", 64'(spi_sck), 0);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_done", 64'(done), 0);
    chk("abort_data", 64'(rd_data), 0);
    rst = 0;
    d0 = done_n;
    repeat (300) tick();
    chk("abort_no_done", 64'(done_n - d0), 0);
    chk("abort_no_valid", 64'(rd_q.size() - r0), 0);
    run_txn(24'hC0FFEE, 8'd1, model_lat(1), 0);

    // start held high: back-to-back transactions
    load_flash(1);
    d0 = done_n;
    start = 1;
    addr = 24'h654321;
    len = 8'd1;
    t0 = cyc;
    wait_done(d0 + 1, model_lat(1) + 50);
    d1 = done_cyc;
    r1 = ss_rise_cyc;
    chk("b2b_lat1", 64'(d1 - t0), 64'(model_lat(1)));
    tick();
    chk("b2b_ss_fall", 64'(ss_fall_cyc), 64'(d1 + 1));
    chk("b2b_ss_gap", 64'((d1 + 1 - r1) >= GAP), 1);
    wait_done(d0 + 2, model_lat(1) + 50);
    start = 0;
    chk("b2b_lat2", 64'(done_cyc - d1), 64'(model_lat(1)));
    repeat (model_lat(1) + 20) tick();
    chk("b2b_stop", 64'(done_n - d0), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
